rtdf_sample_packer: RTL and testbench
=====================================

Name: rtdf_sample_packer

Overview:
- Transmit-side counterpart of the real-time data feed's sample unpacker.
- Packs a stream of 3-bit GPS front-end samples into 16-bit words, using the same continuous LSB-first bitstream the feed's unpacker consumes: sample k occupies stream bits 3k..3k+2, and word w holds stream bits 16w..16w+15.
- Buffers completed words in a small first-word-fall-through FIFO and frames them into fixed-length packets for the Ethernet transmit path.

Parameters:
- FIFO_DEPTH, 4, number of 16-bit word entries in the output FIFO (power of two, at least 2).
- WORDS_PER_PACKET, 96, words per packet before word_last is asserted; must be a multiple of 3 so every packet starts on a sample boundary.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- sample_valid  input  1  sample_data is valid this cycle.
- sample_data  input  3  sample to pack.
- flush  input  1  one-cycle pulse: zero-pad and emit the partial word, then end the packet.
- word_ready  input  1  downstream accepts word_data this cycle.
- word_valid  output  1  FIFO not empty.
- word_data  output  16  FIFO head word.
- word_last  output  1  head word is the final word of its packet.
- fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when a completed word is dropped because the FIFO is full.
- dropped_words  output  9  count of dropped words, saturating at 511.
- packet_count  output  9  count of packets whose last word was written to the FIFO, wrapping.

Behaviour:
- Reset values:
  - Accumulator acc[17:0]=0; fill[4:0]=0; word index=0.
  - FIFO empty; word_valid=0; word_data=0; word_last=0; fifo_count=0.
  - overflow=0; dropped_words=0; packet_count=0.
  - Reset mid-packet discards all partial state. No flush word is emitted.
- Accept (sample_valid=1), with nf=fill+3:
  - Write acc[fill+:3]=sample_data.
  - If nf<16: fill<=nf.
  - If nf>=16: complete word = acc[15:0] including the new bits; acc<=bits above 15 shifted down to bit 0; fill<=nf-16 (0..2).
- Fill sequence from 0: 0,3,...,15,18→2,...,17→1,...,16→0. This completes 3 words per 16 samples.
- Flush:
  - Same-cycle sample_valid is applied first.
  - If the resulting fill>0 (or a word completed this cycle): emit the remaining bits zero-padded as an extra word. If both a completed word and remainder bits exist, emit the completed word this cycle and the padded word the next cycle. The FSM states are RUN, FLUSH2.
  - In FLUSH2, sample_valid is still accepted into the cleared accumulator.
  - The last word emitted by a flush has word_last=1 and resets the word index.
  - Flush with fill=0 and no pending word: no word is emitted; if the word index is >0, the next written word is NOT marked last. Flush on an empty packet is a no-op.
- Packet framing:
  - The word index counts words written to the FIFO.
  - The word at index WORDS_PER_PACKET-1 is written with word_last=1; the index then resets to 0 and packet_count increments.
  - Dropped words do not advance the index.
- FIFO:
  - Stores {last,data}.
  - A word completed at posedge N is visible at word_valid/word_data from cycle N+1 (1-cycle latency).
  - Pop occurs when word_valid && word_ready.
  - Push and pop in the same cycle with FIFO full: the pop frees the slot and the push succeeds (no drop).
  - Push with FIFO full and no pop: the word is dropped, overflow<=1, dropped_words increments (saturating). The accumulator continues unaffected.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- word_data, word_last and word_valid are stable while word_valid=1 and word_ready=0.

Test Plan:
- 16 samples of 3'b101, word_ready=1 -> words 0xDB6D, 0x6DB6, 0xB6DB in order; fill=0 afterward; word_last=0 (WORDS_PER_PACKET=96).
- 6 samples of 3'b111, then flush -> words 0xFFFF then 0x0003; second word has word_last=1; packet_count=1.
- 2 samples of 3'b111, then flush in the same cycle as a third sample 3'b001 -> single word 0x007F, word_last=1; flush with nothing pending -> no word emitted.
- FIFO_DEPTH=4, word_ready=0, 27 samples of 3'b010 -> fifo_count=4, overflow=1, dropped_words=1; then word_ready=1 -> 4 words drain in order.
- WORDS_PER_PACKET=3, 48 samples, word_ready=1 -> 9 words; word_last high on words 3, 6 and 9; packet_count=3.
- Reset asserted after 7 samples with the FIFO holding 1 word -> word_valid=0, fill=0; the next 16 samples produce 3 words aligned from bit 0.

Source files
------------

// File: rtl/rtdf_sample_packer.sv
// rtdf_sample_packer: packs 3-bit samples LSB-first into 16-bit words, buffers them in a FWFT FIFO and frames packets.
module rtdf_sample_packer #(
  parameter int FIFO_DEPTH       = 4,
  parameter int WORDS_PER_PACKET = 96
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_valid,
  input  logic [2:0]                  sample_data,
  input  logic                        flush,
  input  logic                        word_ready,
  output logic                        word_valid,
  output logic [15:0]                 word_data,
  output logic                        word_last,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic [8:0]                  dropped_words,
  output logic [8:0]                  packet_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(WORDS_PER_PACKET);
  typedef enum logic {RUN, FLUSH2} state_t;
  state_t state_q, state_d;
  logic [17:0] acc_q, acc_d, acc_w;
  logic [4:0] fill_q, fill_d, nf;
  logic [15:0] pend_q, pend_d, rem, push_data;
  logic [IW-1:0] widx_q, widx_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [8:0] drop_q, drop_d, pkt_q, pkt_d;
  logic [16:0] mem_q [FIFO_DEPTH];
  logic done, push, push_flush, push_last, pop, push_ok;
  always_comb begin
    acc_w = sample_valid ? acc_q | (18'(sample_data) << fill_q) : acc_q;
    nf = sample_valid ? fill_q + 5'd3 : fill_q;
    done = nf >= 5'd16;
    rem = done ? {14'd0, acc_w[17:16]} : acc_w[15:0];
    acc_d = done ? 18'(acc_w[17:16]) : acc_w;
    fill_d = done ? nf - 5'd16 : nf;
    state_d = RUN;
    pend_d = pend_q;
    push = done;
    push_data = acc_w[15:0];
    push_flush = 1'b0;
    if (state_q == FLUSH2) begin
      push = 1'b1;
      push_data = pend_q;
      push_flush = 1'b1;
    end else if (flush) begin
      // a completed word plus leftover bits needs two writes; park the padded remainder
      if (done && fill_d != 5'd0) begin
        state_d = FLUSH2;
        pend_d = rem;
      end else if (done || nf != 5'd0) begin
        push = 1'b1;
        push_flush = 1'b1;
      end
      acc_d = '0;
      fill_d = '0;
    end
    pop = cnt_q != '0 && word_ready;
    push_ok = push && (!cnt_q[AW] || pop);
    push_last = push_flush || widx_q == IW'(WORDS_PER_PACKET - 1);
    widx_d = push_ok ? (push_last ? '0 : widx_q + 1'b1) : widx_q;
    pkt_d = pkt_q + 9'(push_ok && push_last);
    ovf_d = ovf_q || (push && !push_ok);
    drop_d = drop_q + 9'(push && !push_ok && drop_q != 9'd511);
    wptr_d = wptr_q + AW'(push_ok);
    rptr_d = rptr_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      acc_q <= '0;
      fill_q <= '0;
      pend_q <= '0;
      widx_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      drop_q <= '0;
      pkt_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      fill_q <= fill_d;
      pend_q <= pend_d;
      widx_q <= widx_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
      pkt_q <= pkt_d;
    end
    if (push_ok) mem_q[wptr_q] <= {push_last, push_data};
  end
  assign word_valid = cnt_q != '0;
  assign word_data = word_valid ? mem_q[rptr_q][15:0] : '0;
  assign word_last = word_valid && mem_q[rptr_q][16];
  assign fifo_count = cnt_q;
  assign overflow = ovf_q;
  assign dropped_words = drop_q;
  assign packet_count = pkt_q;
endmodule

// File: tb/tb_rtdf_sample_packer.sv
// tb_rtdf_sample_packer: two packers (96- and 3-word packets) on shared stimulus against a bitstream reference model.
module tb_rtdf_sample_packer;
  logic clk = 1'b0, reset = 1'b1, sample_valid = 1'b0, flush = 1'b0, word_ready = 1'b0;
  logic [2:0] sample_data = '0;
  logic a_word_valid, a_word_last, a_overflow, b_word_valid, b_word_last, b_overflow;
  logic [15:0] a_word_data, b_word_data;
  logic [2:0] a_fifo_count, b_fifo_count;
  logic [8:0] a_dropped_words, a_packet_count, b_dropped_words, b_packet_count;
  int checks = 0, failures = 0;
  bit bits[$];
  logic [16:0] mq0[$], mq1[$];
  logic [15:0] m_pend;
  bit m_fl2, m_ovf;
  int widx0, widx1, pk0, pk1, mdrop;

  always #5 clk = ~clk;

  rtdf_sample_packer #(.FIFO_DEPTH(4), .WORDS_PER_PACKET(96)) dut_a (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data), .flush(flush),
    .word_ready(word_ready), .word_valid(a_word_valid), .word_data(a_word_data), .word_last(a_word_last),
    .fifo_count(a_fifo_count), .overflow(a_overflow), .dropped_words(a_dropped_words), .packet_count(a_packet_count));
  rtdf_sample_packer #(.FIFO_DEPTH(4), .WORDS_PER_PACKET(3)) dut_b (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data), .flush(flush),
    .word_ready(word_ready), .word_valid(b_word_valid), .word_data(b_word_data), .word_last(b_word_last),
    .fifo_count(b_fifo_count), .overflow(b_overflow), .dropped_words(b_dropped_words), .packet_count(b_packet_count));

  task automatic mpush(input logic [15:0] d, input bit force_last);
    bit l0, l1;
    if (mq0.size() < 4) begin
      l0 = force_last || widx0 == 95;
      l1 = force_last || widx1 == 2;
      mq0.push_back({l0, d});
      mq1.push_back({l1, d});
      widx0 = l0 ? 0 : widx0 + 1;
      widx1 = l1 ? 0 : widx1 + 1;
      pk0 += int'(l0);
      pk1 += int'(l1);
    end else begin
      m_ovf = 1;
      if (mdrop < 511) mdrop++;
    end
  endtask

  task automatic cycle(input logic sv, input logic [2:0] sd, input logic fl, input logic rd);
    logic [15:0] w, p;
    bit have;
    sample_valid = sv; sample_data = sd; flush = fl; word_ready = rd;
    @(posedge clk);
    if (mq0.size() > 0 && rd) begin
      void'(mq0.pop_front());
      void'(mq1.pop_front());
    end
    if (sv) for (int i = 0; i < 3; i++) bits.push_back(sd[i]);
    have = bits.size() >= 16;
    w = '0;
    if (have) for (int i = 0; i < 16; i++) w[i] = bits.pop_front();
    p = '0;
    for (int i = 0; i < bits.size(); i++) p[i] = bits[i];
    if (m_fl2) begin
      mpush(m_pend, 1);
      m_fl2 = 0;
    end else if (fl) begin
      if (have && bits.size() > 0) begin
        mpush(w, 0);
        m_pend = p;
        m_fl2 = 1;
      end else if (have) mpush(w, 1);
      else if (bits.size() > 0) mpush(p, 1);
      bits.delete();
    end else if (have) mpush(w, 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_valid = 0; flush = 0; word_ready = 0;
    repeat (2) @(posedge clk);
    bits.delete(); mq0.delete(); mq1.delete();
    m_fl2 = 0; m_ovf = 0; widx0 = 0; widx1 = 0; pk0 = 0; pk1 = 0; mdrop = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_word_valid, a_word_data, a_word_last, a_fifo_count, a_overflow, a_dropped_words, a_packet_count} !== '0) begin
      failures++;
      $display("FAIL reset: got v=%b d=%h l=%b cnt=%0d ovf=%b drop=%0d pkt=%0d want all zero",
               a_word_valid, a_word_data, a_word_last, a_fifo_count, a_overflow, a_dropped_words, a_packet_count);
    end
  endtask

  task automatic test_pattern101();
    logic [15:0] exp [3] = '{16'hDB6D, 16'h6DB6, 16'hB6DB};
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 3'b101, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_word_valid !== 1'b1 || a_word_data !== exp[i] || a_word_last !== 1'b0) begin
        failures++;
        $display("FAIL pattern101 word%0d: got v=%b d=%h l=%b want v=1 d=%h l=0", i, a_word_valid, a_word_data, a_word_last, exp[i]);
      end
      cycle(0, 0, 0, 1);
    end
    cycle(1, 3'b101, 1, 1);
    checks++;
    if (a_word_data !== 16'h0005 || a_word_last !== 1'b1) begin
      failures++;
      $display("FAIL pattern101 realign: got d=%h l=%b want d=0005 l=1", a_word_data, a_word_last);
    end
  endtask

  task automatic test_flush_split();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 3'b111, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    checks++;
    if (a_fifo_count !== 3'd2 || a_word_data !== 16'hFFFF || a_word_last !== 1'b0 || a_packet_count !== 9'd1) begin
      failures++;
      $display("FAIL flush_split first: got cnt=%0d d=%h l=%b pkt=%0d want cnt=2 d=ffff l=0 pkt=1",
               a_fifo_count, a_word_data, a_word_last, a_packet_count);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (a_word_data !== 16'h0003 || a_word_last !== 1'b1) begin
      failures++;
      $display("FAIL flush_split second: got d=%h l=%b want d=0003 l=1", a_word_data, a_word_last);
    end
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    cycle(1, 3'b111, 0, 0);
    cycle(1, 3'b111, 0, 0);
    cycle(1, 3'b001, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    checks++;
    if (a_fifo_count !== 3'd1 || a_word_data !== 16'h007F || a_word_last !== 1'b1 || a_packet_count !== 9'd1) begin
      failures++;
      $display("FAIL flush_same_cycle: got cnt=%0d d=%h l=%b pkt=%0d want cnt=1 d=007f l=1 pkt=1",
               a_fifo_count, a_word_data, a_word_last, a_packet_count);
    end
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 1);
    checks++;
    if (a_word_valid !== 1'b0 || a_packet_count !== 9'd1) begin
      failures++;
      $display("FAIL empty_flush: got v=%b pkt=%0d want v=0 pkt=1", a_word_valid, a_packet_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 27; i++) cycle(1, 3'b010, 0, 0);
    checks++;
    if (a_fifo_count !== 3'd4 || a_overflow !== 1'b1 || a_dropped_words !== 9'd1) begin
      failures++;
      $display("FAIL overflow: got cnt=%0d ovf=%b drop=%0d want cnt=4 ovf=1 drop=1", a_fifo_count, a_overflow, a_dropped_words);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_word_valid !== 1'b1 || {a_word_last, a_word_data} !== mq0[0]) begin
        failures++;
        $display("FAIL overflow drain%0d: got v=%b d=%h want v=1 d=%h", i, a_word_valid, a_word_data, mq0[0][15:0]);
      end
      cycle(0, 0, 0, 1);
    end
    checks++;
    if (a_word_valid !== 1'b0 || a_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow after drain: got v=%b ovf=%b want v=0 ovf=1", a_word_valid, a_overflow);
    end
  endtask

  task automatic test_framing();
    int n = 0;
    logic [8:0] lmask = '0;
    do_reset();
    for (int i = 0; i < 52; i++) begin
      cycle(i < 48, 3'($urandom_range(7)), 0, 1);
      if (b_word_valid) begin
        checks++;
        if ({b_word_last, b_word_data} !== mq1[0]) begin
          failures++;
          $display("FAIL framing word%0d: got l=%b d=%h want l=%b d=%h", n, b_word_last, b_word_data, mq1[0][16], mq1[0][15:0]);
        end
        if (n < 9) lmask[n] = b_word_last;
        n++;
      end
    end
    checks++;
    if (n != 9 || lmask !== 9'b100100100 || b_packet_count !== 9'd3) begin
      failures++;
      $display("FAIL framing summary: got words=%0d lasts=%b pkt=%0d want words=9 lasts=100100100 pkt=3", n, lmask, b_packet_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp [3] = '{16'hDB6D, 16'h6DB6, 16'hB6DB};
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, 3'b110, 0, 0);
    do_reset();
    checks++;
    if (a_word_valid !== 1'b0 || a_fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid: got v=%b cnt=%0d want v=0 cnt=0", a_word_valid, a_fifo_count);
    end
    for (int i = 0; i < 16; i++) cycle(1, 3'b101, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_word_valid !== 1'b1 || a_word_data !== exp[i]) begin
        failures++;
        $display("FAIL reset_mid word%0d: got v=%b d=%h want v=1 d=%h", i, a_word_valid, a_word_data, exp[i]);
      end
      cycle(0, 0, 0, 1);
    end
  endtask

  task automatic test_random();
    logic [16:0] e0, e1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(3) != 0, 3'($urandom_range(7)), $urandom_range(15) == 0, $urandom_range(2) != 0);
      e0 = mq0.size() > 0 ? mq0[0] : '0;
      e1 = mq1.size() > 0 ? mq1[0] : '0;
      checks++;
      if (a_word_valid !== (mq0.size() > 0) || {a_word_last, a_word_data} !== e0 || a_fifo_count !== 3'(mq0.size()) ||
          b_word_valid !== (mq1.size() > 0) || {b_word_last, b_word_data} !== e1 || b_fifo_count !== 3'(mq1.size()) ||
          a_overflow !== m_ovf || a_dropped_words !== 9'(mdrop) || a_packet_count !== 9'(pk0) || b_packet_count !== 9'(pk1)) begin
        failures++;
        $display("FAIL random cyc%0d: got a=%b/%b/%h/%0d b=%b/%b/%h/%0d ovf=%b drop=%0d pk=%0d/%0d want a=%b/%b/%h/%0d b=%b/%b/%h/%0d ovf=%b drop=%0d pk=%0d/%0d",
                 i, a_word_valid, a_word_last, a_word_data, a_fifo_count, b_word_valid, b_word_last, b_word_data, b_fifo_count,
                 a_overflow, a_dropped_words, a_packet_count, b_packet_count,
                 mq0.size() > 0, e0[16], e0[15:0], mq0.size(), mq1.size() > 0, e1[16], e1[15:0], mq1.size(), m_ovf, mdrop, pk0, pk1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern101();
    test_flush_split();
    test_flush_same_cycle();
    test_overflow();
    test_framing();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
